// File: rtl/multi_down_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_down_timer_pkg : channel state encoding and load mode constants |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multi_down_timer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/down_timer_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | down_timer_channel : one down-counter with one-shot / auto-reload    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module down_timer_channel
  import multi_down_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ld_auto,
  input  logic             en,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_auto;
  logic             r_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_auto   <= MODE_ONESHOT;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (ld) begin
        r_count  <= ld_val;
        r_reload <= ld_val;
        r_auto   <= ld_auto;
        r_state  <= (ld_val != '0) ? ST_RUN : ST_IDLE;
      end else if (en && tick) begin
        case (r_state)
          ST_RUN: begin
            if (r_count > WIDTH'(1)) begin
              r_count <= r_count - WIDTH'(1);
            end else if (r_auto == MODE_AUTO) begin
              r_count <= r_reload;
              r_tc    <= 1'b1;
            end else begin
              r_count <= '0;
              r_state <= ST_IDLE;
              r_tc    <= 1'b1;
            end
          end
          default: begin
            // an idle channel holds its count, so it never wraps below zero
            r_count <= r_count;
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);
  assign tc    = r_tc;
  assign busy  = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/multi_down_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_down_timer : NCH independent down-timers sharing a load value; |
// | MULTI_DOWN_TIMER_PRESCALE_EN adds a shared prescaler (presc input).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multi_down_timer
  import multi_down_timer_pkg::*;
#(
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
  parameter int PRESC_W = 8,
`endif
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0]   presc,
`endif
  input  logic [NCH-1:0]       ld,
  input  logic [WIDTH-1:0]     ld_val,
  input  logic                 ld_auto,
  input  logic [NCH-1:0]       en,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       zero,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       busy
);

  logic w_tick;

`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [PRESC_W-1:0] r_presc_lim;

  // The divide ratio is latched only on wrap or load, so a presc change
  // never shortens or stretches the period already in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
      r_presc_lim <= '0;
    end else if ((|ld) || w_tick) begin
      r_presc_cnt <= '0;
      r_presc_lim <= presc;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

  assign w_tick = (r_presc_cnt == r_presc_lim);
`else
  assign w_tick = 1'b1;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    down_timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld[g]),
      .ld_val  (ld_val),
      .ld_auto (ld_auto),
      .en      (en[g]),
      .tick    (w_tick),
      .count   (count[g*WIDTH +: WIDTH]),
      .zero    (zero[g]),
      .tc      (tc[g]),
      .busy    (busy[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_down_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_down_timer : scoreboard bench for multi_down_timer          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multi_down_timer;

  localparam int NCH = 4;
  localparam int W   = 16;

  typedef struct {
    int          ch;
    logic [W-1:0] cnt;
    logic        tc;
    logic        busy;
    logic        zero;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   ld;
  logic [W-1:0]     ld_val;
  logic             ld_auto;
  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] count;
  logic [NCH-1:0]   zero;
  logic [NCH-1:0]   tc;
  logic [NCH-1:0]   busy;
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
  logic [7:0]       presc;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  multi_down_timer #(
    .NCH   (NCH),
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
    .presc   (presc),
`endif
    .ld      (ld),
    .ld_val  (ld_val),
    .ld_auto (ld_auto),
    .en      (en),
    .count   (count),
    .zero    (zero),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic test_reset();
    exp_t e;
    #2;
    for (int c = 0; c < NCH; c++) sb.push_back('{c, 16'd0, 1'b0, 1'b0, 1'b1});
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
        n_fail++;
        $display("FAIL reset ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                 e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_oneshot();
    int   exp_cnt[6] = '{3, 2, 1, 0, 0, 0};
    logic exp_tc[6]  = '{0, 0, 0, 1, 0, 0};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      ld      = (k == 0) ? 4'b0001 : 4'b0000;
      ld_val  = 16'd3;
      ld_auto = 1'b0;
      en      = 4'b0001;
      sb.push_back('{0, 16'(exp_cnt[k]), exp_tc[k], (k < 3), (exp_cnt[k] == 0)});
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL oneshot step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0;
  endtask

  task automatic test_auto();
    int exp_cnt[10] = '{4, 3, 2, 1, 4, 3, 2, 1, 4, 3};
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      ld      = (k == 0) ? 4'b0010 : 4'b0000;
      ld_val  = 16'd4;
      ld_auto = 1'b1;
      en      = 4'b0010;
      sb.push_back('{1, 16'(exp_cnt[k]), (k == 4 || k == 8), 1'b1, 1'b0});
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL auto step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0; ld_auto = 1'b0;
  endtask

  task automatic test_load_priority();
    int exp_cnt[5] = '{9, 8, 7, 10, 9};
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      ld      = (k == 0 || k == 3) ? 4'b0100 : 4'b0000;
      ld_val  = (k == 3) ? 16'd10 : 16'd9;
      ld_auto = 1'b0;
      en      = 4'b0100;
      sb.push_back('{2, 16'(exp_cnt[k]), 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL load_priority step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0;
  endtask

  task automatic test_enable_gap();
    int exp_cnt[6] = '{6, 5, 5, 5, 5, 4};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      ld      = (k == 0) ? 4'b0001 : ((k == 3) ? 4'b0010 : 4'b0000);
      ld_val  = (k == 3) ? 16'd2 : 16'd6;
      ld_auto = 1'b0;
      en      = (k >= 2 && k <= 4) ? 4'b0000 : 4'b0001;
      sb.push_back('{0, 16'(exp_cnt[k]), 1'b0, 1'b1, 1'b0});
      if (k == 3) sb.push_back('{1, 16'd2, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL enable_gap step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0;
  endtask

  task automatic test_multi_load();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      ld      = (k == 0) ? 4'b1111 : ((k == 3) ? 4'b0001 : 4'b0000);
      ld_val  = (k == 3) ? 16'd0 : 16'd1;
      ld_auto = 1'b0;
      en      = 4'b1111;
      for (int c = 0; c < NCH; c++) begin
        if (k == 0)      sb.push_back('{c, 16'd1, 1'b0, 1'b1, 1'b0});
        else if (k == 1) sb.push_back('{c, 16'd0, 1'b1, 1'b0, 1'b1});
        else             sb.push_back('{c, 16'd0, 1'b0, 1'b0, 1'b1});
      end
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL multi_load step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // ch3 runs 8,7,6,5 then reset lands mid-cycle and is held over one edge
    for (int k = 0; k < 7; k++) begin
      ld      = (k == 0) ? 4'b1000 : 4'b0000;
      ld_val  = 16'd8;
      ld_auto = 1'b0;
      en      = 4'b1000;
      if (k < 4) begin
        sb.push_back('{3, 16'(8 - k), 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
      end else if (k == 4) begin
        #3;
        rst = 1'b1;
        #1;
        for (int c = 0; c < NCH; c++) sb.push_back('{c, 16'd0, 1'b0, 1'b0, 1'b1});
      end else begin
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back('{3, 16'd0, 1'b0, 1'b0, 1'b1});
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL reset_mid step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    en = '0;
  endtask

`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
  task automatic test_prescale();
    int   exp_cnt[8] = '{2, 2, 2, 1, 1, 1, 0, 0};
    exp_t e;
    presc = 8'd2;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      ld      = (k == 0) ? 4'b0001 : 4'b0000;
      ld_val  = 16'd2;
      ld_auto = 1'b0;
      en      = 4'b0001;
      sb.push_back('{0, 16'(exp_cnt[k]), (k == 6), (k < 6), (exp_cnt[k] == 0)});
      @(posedge clk); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count[e.ch*W +: W] !== e.cnt || tc[e.ch] !== e.tc || busy[e.ch] !== e.busy || zero[e.ch] !== e.zero) begin
          n_fail++;
          $display("FAIL prescale step%0d ch%0d: got cnt=%0d tc=%b busy=%b zero=%b, want cnt=%0d tc=%b busy=%b zero=%b",
                   k, e.ch, count[e.ch*W +: W], tc[e.ch], busy[e.ch], zero[e.ch], e.cnt, e.tc, e.busy, e.zero);
        end
      end
    end
    ld = '0; en = '0; presc = 8'd0;
  endtask
`endif

  initial begin
    rst     = 1'b1;
    ld      = '0;
    ld_val  = '0;
    ld_auto = 1'b0;
    en      = '0;
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
    presc   = 8'd0;
`endif
    test_reset();
    test_oneshot();
    test_auto();
    test_load_priority();
    test_enable_gap();
    test_multi_load();
    test_reset_mid();
`ifdef MULTI_DOWN_TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
